// File: rtl/daec_pkg.sv
// daec_pkg: 8LC parity-check matrix, interleave split and DAEC parity helpers
//   ip_width/data_width : derived field widths for a message width and stride
//   H_8LC               : 7x42 parity rows, row p = parity bit p
//   ip_split            : returns {ipword, data} packed with data in the low bits
//   daec_parity         : parity of a 42-bit data field against a 7-row matrix
package daec_pkg;
  localparam int SPLIT_MAX = 256;
  function automatic int ip_width(input int msg_w, input int stride);
    return (msg_w + stride - 1) / stride;
  endfunction
  function automatic int data_width(input int msg_w, input int stride);
    return msg_w - ip_width(msg_w, stride);
  endfunction
  // Matrix kept column-wise (column 0 last) so every data bit's syndrome is readable.
  localparam logic [41:0][6:0] H_8LC_COLS = {
    7'h3E, 7'h3D, 7'h3B, 7'h37, 7'h2F, 7'h1F, 7'h70, 7'h68, 7'h64, 7'h62, 7'h61, 7'h58, 7'h54, 7'h52,
    7'h51, 7'h4C, 7'h4A, 7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h34, 7'h32, 7'h31, 7'h2C, 7'h2A, 7'h29,
    7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A, 7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07, 7'h65};
  function automatic logic [6:0][41:0] cols_to_rows(input logic [41:0][6:0] c);
    logic [6:0][41:0] r;
    r = '0;
    for (int d = 0; d < 42; d++)
      for (int p = 0; p < 7; p++)
        r[p][d] = c[d][p];
    return r;
  endfunction
  localparam logic [6:0][41:0] H_8LC = cols_to_rows(H_8LC_COLS);
  // Walks the message once: stride positions go to the IP word, the rest fill data upward,
  // so trailing non-IP bits of a ragged message still land in the data field.
  function automatic logic [SPLIT_MAX-1:0] ip_split(input logic [SPLIT_MAX-1:0] msg, input int msg_w,
                                                    input int stride);
    logic [SPLIT_MAX-1:0] r;
    int d, k;
    r = '0;
    d = 0;
    k = data_width(msg_w, stride);
    for (int i = 0; i < msg_w; i++)
      if (i % stride == 0) begin
        r[k] = msg[i];
        k++;
      end else begin
        r[d] = msg[i];
        d++;
      end
    return r;
  endfunction
  function automatic logic [6:0] daec_parity(input logic [41:0] data, input logic [6:0][41:0] h);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 7; i++) p[i] = ^(data & h[i]);
    return p;
  endfunction
endpackage

// File: rtl/daec_parity_gen.sv
// daec_parity_gen: combinational DAEC parity, one XOR tree per H row
//   data_i   : data field
//   parity_o : parity bits, parity_o[p] = ^(data_i & H[p])
module daec_parity_gen #(
  parameter int D_W = 42,
  parameter int PAR_W = 7,
  parameter logic [PAR_W-1:0][D_W-1:0] H = daec_pkg::H_8LC
) (
  input  logic [D_W-1:0]   data_i,
  output logic [PAR_W-1:0] parity_o
);
  for (genvar p = 0; p < PAR_W; p++) begin : g_row
    assign parity_o[p] = ^(data_i & H[p]);
  end
endmodule

// File: rtl/ip_daec_encoder_pipe.sv
// ip_daec_encoder_pipe: two-stage interleaved-parity + DAEC encoder with pair error injection
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   : message handshake, in_msg_i with inj_en_i/inj_pos_i sidecar
//   out_valid_o/out_ready_i : result handshake
//   out_ipword_o, out_ip_o  : every IP_STRIDE-th message bit and their XOR
//   out_cw_o                : {data, parity}, optionally with an adjacent-pair flip
//   out_count_o             : completed output handshakes
module ip_daec_encoder_pipe
  import daec_pkg::*;
#(
  parameter int MSG_W = 64,
  parameter int IP_STRIDE = 3,
  parameter int PAR_W = 7,
  parameter logic [PAR_W-1:0][MSG_W-ip_width(MSG_W, IP_STRIDE)-1:0] H_MATRIX = H_8LC,
  parameter int CNT_W = 32
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     in_valid_i,
  output logic                                                     in_ready_o,
  input  logic [MSG_W-1:0]                                         in_msg_i,
  input  logic                                                     inj_en_i,
  input  logic [$clog2(MSG_W-ip_width(MSG_W, IP_STRIDE)+PAR_W)-1:0] inj_pos_i,
  output logic                                                     out_valid_o,
  input  logic                                                     out_ready_i,
  output logic [ip_width(MSG_W, IP_STRIDE)-1:0]                    out_ipword_o,
  output logic                                                     out_ip_o,
  output logic [MSG_W-ip_width(MSG_W, IP_STRIDE)+PAR_W-1:0]        out_cw_o,
  output logic [CNT_W-1:0]                                         out_count_o
);
  localparam int IP_W = ip_width(MSG_W, IP_STRIDE);
  localparam int D_W = MSG_W - IP_W;
  localparam int CW_W = D_W + PAR_W;
  localparam int POS_W = $clog2(CW_W);
  logic [SPLIT_MAX-1:0] split;
  logic                 unused_split;
  logic                 s1_valid_q, s1_valid_d, s1_ip_q, s1_inj_q;
  logic [IP_W-1:0]      s1_ipword_q;
  logic [D_W-1:0]       s1_data_q;
  logic [POS_W-1:0]     s1_pos_q;
  logic                 s2_valid_q, s2_valid_d, s2_ip_q;
  logic [IP_W-1:0]      s2_ipword_q;
  logic [CW_W-1:0]      s2_cw_q, s2_cw_d;
  logic [PAR_W-1:0]     parity;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 s2_ready, s1_load, s2_load, deliver;
  assign split = ip_split(SPLIT_MAX'(in_msg_i), MSG_W, IP_STRIDE);
  assign unused_split = ^split[SPLIT_MAX-1:MSG_W];
  daec_parity_gen #(.D_W(D_W), .PAR_W(PAR_W), .H(H_MATRIX)) u_parity (
    .data_i  (s1_data_q),
    .parity_o(parity)
  );
  assign deliver = s2_valid_q && out_ready_i;
  assign s2_ready = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_ready;
  assign s1_load = in_valid_i && in_ready_o;
  assign s2_load = s1_valid_q && s2_ready;
  always_comb begin
    s1_valid_d = s1_load || (s1_valid_q && !s2_ready);
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    count_d = count_q + CNT_W'(deliver);
    // A pair mask shifted past the top truncates to the single MSB, or to nothing.
    s2_cw_d = {s1_data_q, parity} ^ (s1_inj_q ? CW_W'((CW_W + 1)'(3) << s1_pos_q) : '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ipword_q <= '0;
      s1_ip_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_inj_q    <= 1'b0;
      s1_pos_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_ipword_q <= '0;
      s2_ip_q     <= 1'b0;
      s2_cw_q     <= '0;
      count_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
      if (s1_load) begin
        s1_ipword_q <= split[D_W+:IP_W];
        s1_ip_q     <= ^split[D_W+:IP_W];
        s1_data_q   <= split[D_W-1:0];
        s1_inj_q    <= inj_en_i;
        s1_pos_q    <= inj_pos_i;
      end
      if (s2_load) begin
        s2_ipword_q <= s1_ipword_q;
        s2_ip_q     <= s1_ip_q;
        s2_cw_q     <= s2_cw_d;
      end
    end
  end
  assign out_valid_o  = s2_valid_q;
  assign out_ipword_o = s2_ipword_q;
  assign out_ip_o     = s2_ip_q;
  assign out_cw_o     = s2_cw_q;
  assign out_count_o  = count_q;
endmodule

// File: tb/tb_ip_daec_encoder_pipe.sv
// tb_ip_daec_encoder_pipe: directed and random checks of the pipelined 8LC encoder
module tb_ip_daec_encoder_pipe;
  localparam logic [6:0] COLS [42] = '{
    7'h65, 7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19, 7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26,
    7'h29, 7'h2A, 7'h2C, 7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49, 7'h4A, 7'h4C, 7'h51,
    7'h52, 7'h54, 7'h58, 7'h61, 7'h62, 7'h64, 7'h68, 7'h70, 7'h1F, 7'h2F, 7'h37, 7'h3B, 7'h3D, 7'h3E};
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, inj_en, out_valid, out_ready, out_ip;
  logic [63:0] in_msg;
  logic [5:0]  inj_pos;
  logic [21:0] out_ipword;
  logic [48:0] out_cw;
  logic [31:0] out_count;
  int          checks = 0, errors = 0, cnt_exp = 0;
  always #5 clk = ~clk;
  ip_daec_encoder_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_msg_i(in_msg),
    .inj_en_i(inj_en), .inj_pos_i(inj_pos), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_ipword_o(out_ipword), .out_ip_o(out_ip), .out_cw_o(out_cw), .out_count_o(out_count)
  );
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Golden encoder: {ipword, ip, cw}; data filled MSB-first from the highest non-IP bit.
  function automatic logic [71:0] model(input logic [63:0] m, input logic ie, input int pos);
    logic [21:0] ipw;
    logic [41:0] d;
    logic [6:0]  p;
    logic [48:0] cw;
    int          n;
    ipw = '0;
    d = '0;
    p = '0;
    n = 0;
    for (int k = 0; k < 22; k++) ipw[k] = m[3*k];
    for (int i = 63; i >= 0; i--)
      if (i % 3 != 0) begin
        d[41-n] = m[i];
        n++;
      end
    for (int j = 0; j < 42; j++) if (d[j]) p ^= COLS[j];
    cw = {d, p};
    if (ie) for (int b = pos; b <= pos + 1; b++) if (b < 49) cw[b] = ~cw[b];
    return {ipw, ^ipw, cw};
  endfunction
  task automatic one(input logic [63:0] m, input logic ie, input logic [5:0] pos, output logic [71:0] seen);
    logic [71:0] e;
    e = model(m, ie, int'(pos));
    @(posedge clk); #1;
    in_valid = 1'b1; in_msg = m; inj_en = ie; inj_pos = pos; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; inj_en = 1'b0;
    chk("lat1_valid", 72'(out_valid), 72'(0));
    @(posedge clk); #1;
    chk("lat2_valid", 72'(out_valid), 72'(1));
    seen = {out_ipword, out_ip, out_cw};
    chk("word_model", seen, e);
    cnt_exp++;
    @(posedge clk); #1;
    chk("count", 72'(out_count), 72'(cnt_exp));
    chk("drained", 72'(out_valid), 72'(0));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [71:0] seen, held;
    logic [71:0] q[$];
    logic [63:0] msgs[8];
    logic        injs[8];
    logic [5:0]  poss[8];
    int          nacc, ndel;
    logic        stall;
    rst = 1'b1; in_valid = 1'b0; in_msg = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_outputs", {out_ipword, out_ip, out_cw}, 72'(0));
    chk("rst_count", 72'(out_count), 72'(0));
    rst = 1'b0;
    one(64'h0, 1'b0, 6'd0, seen);
    chk("t1_zero", seen, 72'(0));
    one(64'h1, 1'b0, 6'd0, seen);
    chk("t2_bit0", seen, {22'h1, 1'b1, 49'h0});
    one(64'h2, 1'b0, 6'd0, seen);
    chk("t3_bit1", seen, {22'h0, 1'b0, 49'h0E5});
    one(64'h2, 1'b1, 6'd0, seen);
    chk("t4_inj0", seen, {22'h0, 1'b0, 49'h0E6});
    one(64'h2, 1'b1, 6'd48, seen);
    chk("t4_inj48", seen, {22'h0, 1'b0, 49'h10000000000E5});
    one(64'h2, 1'b1, 6'd49, seen);
    chk("t4_inj49", seen, {22'h0, 1'b0, 49'h0E5});
    one(64'h2, 1'b1, 6'd63, seen);
    chk("t4_inj63", seen, {22'h0, 1'b0, 49'h0E5});
    one(64'h8000_0000_0000_0000, 1'b1, 6'd7, seen);
    chk("msb_ip", 72'(seen[71:49]), {49'h0, 22'h200000, 1'b1});
    one({$urandom, $urandom}, 1'b1, 6'($urandom_range(0, 47)), seen);
    one({$urandom, $urandom}, 1'b0, 6'd0, seen);
    for (int i = 0; i < 8; i++) begin
      msgs[i] = {$urandom, $urandom};
      injs[i] = 1'($urandom_range(0, 1));
      poss[i] = 6'($urandom_range(0, 63));
    end
    @(posedge clk); #1;
    rst = 1'b1; #1; rst = 1'b0;
    nacc = 0; ndel = 0; stall = 1'b0; held = '0;
    for (int c = 0; c < 100 && ndel < 8; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid = nacc < 8;
      if (nacc < 8) begin
        in_msg = msgs[nacc]; inj_en = injs[nacc]; inj_pos = poss[nacc];
      end
      #5;
      chk("stream_count", 72'(out_count), 72'(ndel));
      if (stall) begin
        chk("stall_valid", 72'(out_valid), 72'(1));
        chk("stall_hold", {out_ipword, out_ip, out_cw}, held);
      end
      if (out_valid && out_ready) begin
        chk("stream_no_dup", 72'(q.size() != 0), 72'(1));
        if (q.size() != 0) chk("stream_word", {out_ipword, out_ip, out_cw}, q.pop_front());
        ndel++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(msgs[nacc], injs[nacc], int'(poss[nacc])));
        nacc++;
      end
      stall = out_valid && !out_ready;
      held = {out_ipword, out_ip, out_cw};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; inj_en = 1'b0;
    chk("stream_delivered", 72'(ndel), 72'(8));
    chk("stream_queue_empty", 72'(q.size()), 72'(0));
    chk("stream_count_final", 72'(out_count), 72'(8));
    chk("stream_idle", 72'(out_valid), 72'(0));
    in_valid = 1'b1; in_msg = {$urandom, $urandom}; out_ready = 1'b0;
    @(posedge clk); #1;
    in_msg = {$urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_in_ready", 72'(in_ready), 72'(0));
    chk("full_out_valid", 72'(out_valid), 72'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 72'(out_valid), 72'(0));
    chk("midrst_count", 72'(out_count), 72'(0));
    chk("midrst_outputs", {out_ipword, out_ip, out_cw}, 72'(0));
    chk("midrst_in_ready", 72'(in_ready), 72'(1));
    #1 rst = 1'b0;
    cnt_exp = 0;
    one({$urandom, $urandom}, 1'b1, 6'd20, seen);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
